// File: rtl/slew_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slew_monitor_pkg
// Description : Shared definitions for the slew-rate monitor: state
//               encoding, direction codes and default widths.
// Contents    : state_e (3-bit state field), DIR_* codes, DEF_* widths,
//               dir_of_state() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package slew_monitor_pkg;

  // Default widths for the monitor
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_STEP_WIDTH = 3;
  localparam int DEF_SETTLE_CNT = 4;
  localparam int DEF_CNT_WIDTH  = 8;

  // Monitor state, 3-bit encoded
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_HOLD      = 3'd3,
    ST_SETTLED   = 3'd4
  } state_e;

  // Ramp direction codes
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Direction reported for a given state
  function automatic logic [1:0] dir_of_state(input state_e st);
    logic [1:0] dir;
    dir = DIR_NONE;
    if (st == ST_RAMP_UP) begin
      dir = DIR_UP;
    end else if (st == ST_RAMP_DOWN) begin
      dir = DIR_DOWN;
    end
    return dir;
  endfunction

  // True for the two ramp states
  function automatic logic is_ramp(input state_e st);
    return (st == ST_RAMP_UP) || (st == ST_RAMP_DOWN);
  endfunction

endpackage : slew_monitor_pkg
`default_nettype wire

// File: rtl/slew_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear and load-one.
//               Priority: clear > load_one > inc. Stops at all-ones.
// Ports       : clk_i      - clock
//               reset_n_i  - synchronous active-low reset
//               clear_i    - force count to 0
//               load_one_i - force count to 1
//               inc_i      - increment unless saturated
//               count_o    - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             load_one_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_one_i) begin
      count_d = WIDTH'(1);
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/slew_monitor.sv
`default_nettype none
// ============================================================================
// Module      : slew_monitor
// Description : Runtime checker for the output of a rate limiter. Each valid
//               sample is compared with the previous one against the step
//               limit in force; step violations and target overshoots are
//               pulsed, ramp direction and settling are reported.
// Config      : SLEW_MONITOR_STATS_EN - builds the violation and ramp-length
//               statistics counters; otherwise those outputs are tied to 0.
// Ports       : clk_i          - clock, rising edge
//               reset_n_i      - synchronous active-low reset
//               sample_valid_i - sample present this cycle
//               sample_i       - rate-limited value
//               target_i       - value the limiter is tracking toward
//               step_limit_i   - maximum allowed change per sample
//               violation_o    - one-cycle pulse, step exceeded limit
//               overshoot_o    - one-cycle pulse, sample crossed target
//               delta_mag_o    - magnitude of last checked change
//               direction_o    - 00 none, 01 up, 10 down
//               settled_o      - high while settled on target
//               viol_count_o   - saturating violation count
//               ramp_len_o     - samples in current ramp, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module slew_monitor
  import slew_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  parameter int SETTLE_CNT = DEF_SETTLE_CNT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  input  logic [STEP_WIDTH-1:0] step_limit_i,
  output logic                  violation_o,
  output logic                  overshoot_o,
  output logic [DATA_WIDTH-1:0] delta_mag_o,
  output logic [1:0]            direction_o,
  output logic                  settled_o,
  output logic [CNT_WIDTH-1:0]  viol_count_o,
  output logic [CNT_WIDTH-1:0]  ramp_len_o
);

  localparam int SC_W = $clog2(SETTLE_CNT + 1);
  localparam logic [SC_W-1:0] SETTLE_MAX = SC_W'(SETTLE_CNT);
  // Common width so the step limit compares correctly whichever is wider
  localparam int CMP_W = (DATA_WIDTH > STEP_WIDTH) ? DATA_WIDTH : STEP_WIDTH;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_e                state_q,     state_d;
  logic [DATA_WIDTH-1:0] prev_q,      prev_d;
  logic                  prev_ok_q,   prev_ok_d;
  logic [SC_W-1:0]       settle_q,    settle_d;
  logic                  violation_q, violation_d;
  logic                  overshoot_q, overshoot_d;
  logic [DATA_WIDTH-1:0] delta_mag_q, delta_mag_d;
  logic [1:0]            direction_q, direction_d;
  logic                  settled_q,   settled_d;

  // --------------------------------------------------------------------------
  // Step arithmetic
  // --------------------------------------------------------------------------
  logic signed [DATA_WIDTH:0] delta;
  logic signed [DATA_WIDTH:0] delta_neg;
  logic [DATA_WIDTH-1:0]      delta_mag;
  logic                       delta_pos;
  logic                       delta_negv;
  logic [CMP_W-1:0]           sample_ext;
  logic [CMP_W-1:0]           step_ext;
  logic [CMP_W-1:0]           mag_ext;
  logic                       exempt;
  logic                       step_bad;
  logic                       cross_bad;
  logic                       on_target;

  // Both operands are zero-extended so the difference is exact in N+1 bits
  assign delta      = $signed({1'b0, sample_i}) - $signed({1'b0, prev_q});
  assign delta_neg  = -delta;
  assign delta_negv = delta[DATA_WIDTH];
  assign delta_pos  = !delta_negv && (delta != '0);
  // |delta| never exceeds 2^N-1, so the low N bits hold it exactly
  assign delta_mag  = delta_negv ? delta_neg[DATA_WIDTH-1:0]
                                 : delta[DATA_WIDTH-1:0];

  assign sample_ext = CMP_W'(sample_i);
  assign step_ext   = CMP_W'(step_limit_i);
  assign mag_ext    = CMP_W'(delta_mag);

  // Samples at or below the limit are passed straight through by the
  // limiter, so they are never flagged.
  assign exempt    = (sample_ext <= step_ext);
  assign step_bad  = (step_limit_i == '0) ? (delta != '0) : (mag_ext > step_ext);
  assign cross_bad = (delta_pos  && (prev_q < target_i) && (sample_i > target_i)) ||
                     (delta_negv && (prev_q > target_i) && (sample_i < target_i));
  assign on_target = (sample_i == target_i);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
    settle_d    = settle_q;
    violation_d = 1'b0;
    overshoot_d = 1'b0;
    delta_mag_d = delta_mag_q;
    direction_d = direction_q;
    settled_d   = settled_q;

    if (sample_valid_i) begin
      prev_d = sample_i;
      if (!prev_ok_q) begin
        // First sample only seeds the reference; nothing to compare against
        prev_ok_d   = 1'b1;
        delta_mag_d = '0;
        if ((SETTLE_CNT == 1) && on_target) begin
          state_d = ST_SETTLED;
        end else begin
          state_d = ST_HOLD;
        end
      end else begin
        delta_mag_d = delta_mag;
        violation_d = !exempt && step_bad;
        overshoot_d = cross_bad;
        if (on_target) begin
          settle_d = (settle_q >= SETTLE_MAX) ? SETTLE_MAX : settle_q + SC_W'(1);
          state_d  = (settle_d == SETTLE_MAX) ? ST_SETTLED : ST_HOLD;
        end else begin
          settle_d = '0;
          if (delta_pos) begin
            state_d = ST_RAMP_UP;
          end else if (delta_negv) begin
            state_d = ST_RAMP_DOWN;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      direction_d = dir_of_state(state_d);
      settled_d   = (state_d == ST_SETTLED);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      settle_q    <= '0;
      violation_q <= 1'b0;
      overshoot_q <= 1'b0;
      delta_mag_q <= '0;
      direction_q <= DIR_NONE;
      settled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      settle_q    <= settle_d;
      violation_q <= violation_d;
      overshoot_q <= overshoot_d;
      delta_mag_q <= delta_mag_d;
      direction_q <= direction_d;
      settled_q   <= settled_d;
    end
  end

  assign violation_o = violation_q;
  assign overshoot_o = overshoot_q;
  assign delta_mag_o = delta_mag_q;
  assign direction_o = direction_q;
  assign settled_o   = settled_q;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef SLEW_MONITOR_STATS_EN
  logic ramp_enter;
  logic ramp_stay;
  logic ramp_clear;

  // A reversal counts as a fresh ramp because the state itself changes
  assign ramp_enter = sample_valid_i && is_ramp(state_d) && (state_d != state_q);
  assign ramp_stay  = sample_valid_i && is_ramp(state_d) && (state_d == state_q);
  assign ramp_clear = sample_valid_i && !is_ramp(state_d);

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_viol_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (1'b0),
    .load_one_i (1'b0),
    .inc_i      (violation_d),
    .count_o    (viol_count_o)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_ramp_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (ramp_clear),
    .load_one_i (ramp_enter),
    .inc_i      (ramp_stay),
    .count_o    (ramp_len_o)
  );
`else
  assign viol_count_o = '0;
  assign ramp_len_o   = '0;
`endif

endmodule : slew_monitor
`default_nettype wire

// File: tb/tb_slew_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_slew_monitor
// Description : Self-checking bench for slew_monitor. Directed scenarios use
//               hand-derived constants; the random scenario compares against
//               an arithmetic reference model of the monitoring rules.
// Config      : SLEW_MONITOR_STATS_EN - also checks the statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slew_monitor;

  localparam int DW  = 6;
  localparam int SW  = 3;
  localparam int SC  = 4;
  localparam int CW  = 8;
  localparam int DMAX = (1 << DW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          sample_valid_i = 1'b0;
  logic [DW-1:0] sample_i = '0;
  logic [DW-1:0] target_i = '0;
  logic [SW-1:0] step_limit_i = '0;
  logic          violation_o;
  logic          overshoot_o;
  logic [DW-1:0] delta_mag_o;
  logic [1:0]    direction_o;
  logic          settled_o;
  logic [CW-1:0] viol_count_o;
  logic [CW-1:0] ramp_len_o;

  int tests_run = 0;
  int fails = 0;

  slew_monitor #(
    .DATA_WIDTH (DW),
    .STEP_WIDTH (SW),
    .SETTLE_CNT (SC),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .target_i       (target_i),
    .step_limit_i   (step_limit_i),
    .violation_o    (violation_o),
    .overshoot_o    (overshoot_o),
    .delta_mag_o    (delta_mag_o),
    .direction_o    (direction_o),
    .settled_o      (settled_o),
    .viol_count_o   (viol_count_o),
    .ramp_len_o     (ramp_len_o)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  // Reference model: plain arithmetic on the monitoring rules
  // ------------------------------------------------------------------------
  bit m_have_prev;
  int m_prev;
  int m_matches;     // consecutive on-target samples, capped at SC
  int m_ramp;        // +1 rising ramp, -1 falling ramp, 0 not ramping
  int m_viol_total;
  int m_ramp_len;
  int e_viol, e_ovs, e_mag, e_dir, e_settled, e_vc, e_rl;

  task automatic model_reset();
    m_have_prev = 0; m_prev = 0; m_matches = 0; m_ramp = 0;
    m_viol_total = 0; m_ramp_len = 0;
    e_viol = 0; e_ovs = 0; e_mag = 0; e_dir = 0; e_settled = 0; e_vc = 0; e_rl = 0;
  endtask

  task automatic model_apply(input bit v, input int s, input int t, input int lim);
    int d;
    e_viol = 0;
    e_ovs  = 0;
    if (v) begin
      if (!m_have_prev) begin
        m_have_prev = 1;
        e_mag = 0;
        m_ramp = 0;
        m_ramp_len = 0;
        e_settled = (SC == 1 && s == t) ? 1 : 0;
      end else begin
        d = s - m_prev;
        e_mag = (d < 0) ? -d : d;
        if (s > lim) e_viol = (lim == 0) ? (d != 0) : (e_mag > lim);
        e_ovs = ((d > 0) && (m_prev < t) && (s > t)) || ((d < 0) && (m_prev > t) && (s < t));
        if (s == t) begin
          m_matches = (m_matches + 1 > SC) ? SC : m_matches + 1;
          e_settled = (m_matches == SC);
          m_ramp = 0;
          m_ramp_len = 0;
        end else begin
          m_matches = 0;
          e_settled = 0;
          if (d == 0) begin
            m_ramp = 0;
            m_ramp_len = 0;
          end else begin
            if (m_ramp == ((d > 0) ? 1 : -1)) m_ramp_len = (m_ramp_len < CMAX) ? m_ramp_len + 1 : CMAX;
            else m_ramp_len = 1;
            m_ramp = (d > 0) ? 1 : -1;
          end
        end
        if (e_viol != 0 && m_viol_total < CMAX) m_viol_total++;
      end
      m_prev = s;
      e_dir = (m_ramp == 1) ? 1 : (m_ramp == -1) ? 2 : 0;
    end
`ifdef SLEW_MONITOR_STATS_EN
    e_vc = m_viol_total;
    e_rl = m_ramp_len;
`else
    e_vc = 0;
    e_rl = 0;
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit
  task automatic cycle(input bit v, input int s, input int t, input int lim, input bit rn);
    sample_valid_i = v;
    sample_i       = s[DW-1:0];
    target_i       = t[DW-1:0];
    step_limit_i   = lim[SW-1:0];
    reset_n_i      = rn;
    @(posedge clk);
    if (!rn) model_reset();
    else model_apply(v, s, t, lim);
    #1;
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0);
  endtask

  // ------------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, $urandom_range(0, DMAX), $urandom_range(0, DMAX), 0, 0);
      tests_run++;
      if ({violation_o, overshoot_o, delta_mag_o, direction_o, settled_o, viol_count_o, ramp_len_o} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got viol=%0d ovs=%0d mag=%0d dir=%0d set=%0d vc=%0d rl=%0d, want all 0",
                 violation_o, overshoot_o, delta_mag_o, direction_o, settled_o, viol_count_o, ramp_len_o);
      end
    end
    cycle(1, 1, 20, 3, 1);  // first sample after reset: would be a step of 1 if checked
    cycle(1, 10, 20, 3, 1); // checked step 9 > 3
    tests_run++;
    if (violation_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_second_checked: got violation=%0d want 1", violation_o);
    end
    do_reset();
    cycle(1, 50, 20, 0, 1);
    tests_run++;
    if (violation_o !== 1'b0 || direction_o !== 2'b00 || delta_mag_o !== '0) begin
      fails++;
      $display("FAIL reset_first_unchecked: got viol=%0d dir=%0d mag=%0d want 0 0 0",
               violation_o, direction_o, delta_mag_o);
    end
  endtask

  task automatic test_legal_ramp();
    int smp[8]   = '{10, 13, 16, 19, 20, 20, 20, 20};
    int dir[8]   = '{0, 1, 1, 1, 0, 0, 0, 0};
    int setl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    int rlen[8]  = '{0, 1, 2, 3, 0, 0, 0, 0};
    int want_rl;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, smp[i], 20, 3, 1);
`ifdef SLEW_MONITOR_STATS_EN
      want_rl = rlen[i];
`else
      want_rl = 0;
`endif
      tests_run++;
      if (violation_o !== 1'b0 || int'(direction_o) != dir[i] || int'(settled_o) != setl[i] ||
          int'(ramp_len_o) != want_rl) begin
        fails++;
        $display("FAIL legal_ramp[%0d]: got viol=%0d dir=%0d set=%0d rl=%0d want 0 %0d %0d %0d",
                 i, violation_o, direction_o, settled_o, ramp_len_o, dir[i], setl[i], want_rl);
      end
    end
  endtask

  task automatic test_violation();
    int want_vc;
    do_reset();
    cycle(1, 10, 40, 3, 1);
    cycle(1, 15, 40, 3, 1);
`ifdef SLEW_MONITOR_STATS_EN
    want_vc = 1;
`else
    want_vc = 0;
`endif
    tests_run++;
    if (violation_o !== 1'b1 || delta_mag_o !== 6'd5 || direction_o !== 2'b01 || int'(viol_count_o) != want_vc) begin
      fails++;
      $display("FAIL step_violation: got viol=%0d mag=%0d dir=%0d vc=%0d want 1 5 1 %0d",
               violation_o, delta_mag_o, direction_o, viol_count_o, want_vc);
    end
    cycle(0, 0, 40, 3, 1);
    tests_run++;
    if (violation_o !== 1'b0 || delta_mag_o !== 6'd5 || direction_o !== 2'b01) begin
      fails++;
      $display("FAIL violation_pulse_hold: got viol=%0d mag=%0d dir=%0d want 0 5 1",
               violation_o, delta_mag_o, direction_o);
    end
  endtask

  task automatic test_exempt_overshoot();
    do_reset();
    cycle(1, 30, 5, 3, 1);
    cycle(1, 2, 5, 3, 1);
    tests_run++;
    if (violation_o !== 1'b0 || overshoot_o !== 1'b1 || direction_o !== 2'b10 || delta_mag_o !== 6'd28) begin
      fails++;
      $display("FAIL exempt_overshoot: got viol=%0d ovs=%0d dir=%0d mag=%0d want 0 1 2 28",
               violation_o, overshoot_o, direction_o, delta_mag_o);
    end
    cycle(1, 5, 5, 3, 1);
    tests_run++;
    if (direction_o !== 2'b00 || settled_o !== 1'b0 || overshoot_o !== 1'b0) begin
      fails++;
      $display("FAIL hold_after_overshoot: got dir=%0d set=%0d ovs=%0d want 0 0 0",
               direction_o, settled_o, overshoot_o);
    end
  endtask

  task automatic test_frozen();
    do_reset();
    cycle(1, 10, 40, 0, 1);
    cycle(1, 10, 40, 0, 1);
    tests_run++;
    if (violation_o !== 1'b0) begin
      fails++;
      $display("FAIL frozen_equal: got viol=%0d want 0", violation_o);
    end
    cycle(1, 11, 40, 0, 1);
    tests_run++;
    if (violation_o !== 1'b1 || delta_mag_o !== 6'd1) begin
      fails++;
      $display("FAIL frozen_step: got viol=%0d mag=%0d want 1 1", violation_o, delta_mag_o);
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    cycle(1, 10, 50, 3, 1);
    cycle(1, 13, 50, 3, 1);
    cycle(1, 16, 50, 3, 0);
    tests_run++;
    if ({violation_o, delta_mag_o, direction_o} !== '0) begin
      fails++;
      $display("FAIL mid_ramp_reset: got viol=%0d mag=%0d dir=%0d want 0 0 0",
               violation_o, delta_mag_o, direction_o);
    end
    cycle(1, 30, 50, 3, 1);
    tests_run++;
    if (violation_o !== 1'b0 || direction_o !== 2'b00) begin
      fails++;
      $display("FAIL after_reset_unchecked: got viol=%0d dir=%0d want 0 0", violation_o, direction_o);
    end
    cycle(1, 40, 50, 3, 1);
    tests_run++;
    if (violation_o !== 1'b1 || delta_mag_o !== 6'd10) begin
      fails++;
      $display("FAIL after_reset_checked: got viol=%0d mag=%0d want 1 10", violation_o, delta_mag_o);
    end
  endtask

  task automatic test_back_to_back();
    int s, t, lim, tmp;
    bit v, rn;
    do_reset();
    s = 20; t = 30; lim = 3;
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 4) != 0);
      rn = ($urandom_range(0, 80) != 0);
      if ($urandom_range(0, 14) == 0) t = $urandom_range(0, DMAX);
      if ($urandom_range(0, 9) == 0) lim = $urandom_range(0, 7);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          tmp = s + $urandom_range(0, 8) - 4;
          s = (tmp < 0) ? 0 : (tmp > DMAX) ? DMAX : tmp;
        end
        5, 6, 7: s = t;
        default: s = $urandom_range(0, DMAX);
      endcase
      cycle(v, s, t, lim, rn);
      tests_run++;
      if (int'(violation_o) != e_viol || int'(overshoot_o) != e_ovs || int'(delta_mag_o) != e_mag ||
          int'(direction_o) != e_dir || int'(settled_o) != e_settled ||
          int'(viol_count_o) != e_vc || int'(ramp_len_o) != e_rl) begin
        fails++;
        $display("FAIL random[%0d]: got viol=%0d ovs=%0d mag=%0d dir=%0d set=%0d vc=%0d rl=%0d want %0d %0d %0d %0d %0d %0d %0d",
                 i, violation_o, overshoot_o, delta_mag_o, direction_o, settled_o, viol_count_o, ramp_len_o,
                 e_viol, e_ovs, e_mag, e_dir, e_settled, e_vc, e_rl);
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_legal_ramp();
    test_violation();
    test_exempt_overshoot();
    test_frozen();
    test_reset_mid_ramp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule : tb_slew_monitor
`default_nettype wire
